// File: rtl/decode_stage_pipelined_pkg.sv
// Shared opcode/funct encodings, ALU operation codes and control-word layout
// for the pipelined decode stage.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    localparam logic [3:0] ALU_OP_NOP = 4'd0;
    localparam logic [3:0] ALU_OP_ADD = 4'd1;
    localparam logic [3:0] ALU_OP_SUB = 4'd2;
    localparam logic [3:0] ALU_OP_AND = 4'd3;
    localparam logic [3:0] ALU_OP_OR  = 4'd4;
    localparam logic [3:0] ALU_OP_SLT = 4'd5;
    localparam logic [3:0] ALU_OP_SLL = 4'd6;
    localparam logic [3:0] ALU_OP_SRL = 4'd7;

    localparam int SYSCALL_EXIT = 10;

    typedef enum logic [1:0] {
        DEST_NONE,
        DEST_RD,
        DEST_RT,
        DEST_LINK
    } dest_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       link;
        logic [3:0] alu_op;
        dest_sel_e  dest_sel;
        logic       zero_ext;
        logic       reads_rs;
        logic       reads_rt;
        logic       is_beq;
        logic       is_bne;
        logic       is_jtarget;
        logic       is_jr;
        logic       is_syscall;
    } ctrl_t;

    function automatic logic [3:0] funct_alu_op(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_OP_ADD;
            FN_SUB:  return ALU_OP_SUB;
            FN_AND:  return ALU_OP_AND;
            FN_OR:   return ALU_OP_OR;
            FN_SLT:  return ALU_OP_SLT;
            FN_SLL:  return ALU_OP_SLL;
            FN_SRL:  return ALU_OP_SRL;
            default: return ALU_OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_pipelined_register_file.sv
// Two-read/one-write register file; register 0 is hard-wired to zero and a
// same-cycle write is forwarded to any matching nonzero read port.
module register_file #(
    parameter int  DATA_WIDTH = 32,
    parameter int  REG_COUNT  = 32,
    localparam int ID_WIDTH   = $clog2(REG_COUNT)
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  write_en_i,
    input  logic [ID_WIDTH-1:0]   write_id_i,
    input  logic [DATA_WIDTH-1:0] write_value_i,
    input  logic [ID_WIDTH-1:0]   read_id_a_i,
    output logic [DATA_WIDTH-1:0] read_value_a_o,
    input  logic [ID_WIDTH-1:0]   read_id_b_i,
    output logic [DATA_WIDTH-1:0] read_value_b_o
);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else if (write_en_i && write_id_i != '0) begin
            regs_q[write_id_i] <= write_value_i;
        end
    end

    always_comb begin
        read_value_a_o = '0;
        read_value_b_o = '0;
        if (read_id_a_i != '0)
            read_value_a_o = (write_en_i && write_id_i == read_id_a_i) ? write_value_i : regs_q[read_id_a_i];
        if (read_id_b_i != '0)
            read_value_b_o = (write_en_i && write_id_i == read_id_b_i) ? write_value_i : regs_q[read_id_b_i];
    end

endmodule

// File: rtl/decode_stage_pipelined.sv
// Pipelined MIPS decode stage: bypassed register file, branch/jump resolution,
// load-use bubble insertion, sticky exit halt and a valid/ready ID/EX register.
module decode_stage_pipelined
    import decode_pkg::*;
#(
    parameter int  DATA_WIDTH      = 32,
    parameter int  REG_COUNT       = 32,
    parameter int  LINK_REG        = 31,
    parameter int  STALL_CNT_WIDTH = 16,
    localparam int REG_ID_WIDTH    = $clog2(REG_COUNT)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                instruction,
    input  logic [DATA_WIDTH-1:0]      pc_plus_four,
    input  logic                       reg_write_W,
    input  logic [REG_ID_WIDTH-1:0]    writeback_id,
    input  logic [DATA_WIDTH-1:0]      writeback_value,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_rs_value,
    output logic [DATA_WIDTH-1:0]      out_rt_value,
    output logic [DATA_WIDTH-1:0]      out_immediate,
    output logic [DATA_WIDTH-1:0]      out_link_value,
    output logic [REG_ID_WIDTH-1:0]    out_dest_id,
    output logic [4:0]                 out_shamt,
    output logic                       out_reg_write,
    output logic                       out_mem_to_reg,
    output logic                       out_mem_write,
    output logic                       out_alu_src,
    output logic                       out_link,
    output logic [3:0]                 out_alu_op,
    output logic                       jump,
    output logic [DATA_WIDTH-1:0]      jump_address,
    output logic                       halted,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rsField, rtField, rdField, shamtField;
    logic [15:0] imm16;
    logic [25:0] target26;

    assign opcode     = instruction[31:26];
    assign rsField    = instruction[25:21];
    assign rtField    = instruction[20:16];
    assign rdField    = instruction[15:11];
    assign shamtField = instruction[10:6];
    assign funct      = instruction[5:0];
    assign imm16      = instruction[15:0];
    assign target26   = instruction[25:0];

    ctrl_t ctrl;

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        ctrl.reg_write = 1'b1; ctrl.dest_sel = DEST_RD;
                        ctrl.reads_rs  = 1'b1; ctrl.reads_rt = 1'b1;
                        ctrl.alu_op    = funct_alu_op(funct);
                    end
                    FN_SLL, FN_SRL: begin
                        ctrl.reg_write = 1'b1; ctrl.dest_sel = DEST_RD;
                        ctrl.reads_rt  = 1'b1; ctrl.alu_op = funct_alu_op(funct);
                    end
                    FN_JR:      begin ctrl.is_jr = 1'b1; ctrl.reads_rs = 1'b1; end
                    FN_SYSCALL: begin ctrl.is_syscall = 1'b1; ctrl.reads_rs = 1'b1; end
                    default: ;
                endcase
            end
            OP_J:   ctrl.is_jtarget = 1'b1;
            OP_JAL: begin
                ctrl.is_jtarget = 1'b1; ctrl.reg_write = 1'b1;
                ctrl.link       = 1'b1; ctrl.dest_sel  = DEST_LINK;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.is_beq   = (opcode == OP_BEQ); ctrl.is_bne = (opcode == OP_BNE);
                ctrl.reads_rs = 1'b1; ctrl.reads_rt = 1'b1; ctrl.alu_op = ALU_OP_SUB;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
                ctrl.reg_write  = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.dest_sel   = DEST_RT; ctrl.reads_rs = 1'b1;
                ctrl.mem_to_reg = (opcode == OP_LW);
                ctrl.zero_ext   = (opcode == OP_ANDI) || (opcode == OP_ORI);
                ctrl.alu_op     = (opcode == OP_SLTI) ? ALU_OP_SLT :
                                  (opcode == OP_ANDI) ? ALU_OP_AND :
                                  (opcode == OP_ORI)  ? ALU_OP_OR  : ALU_OP_ADD;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OP_ADD;
                ctrl.reads_rs  = 1'b1; ctrl.reads_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Syscall reads its service number from register 2 through the rs port,
    // so it also participates in load-use detection on $2.
    logic [REG_ID_WIDTH-1:0] rsId, rtId, destId;
    logic [DATA_WIDTH-1:0]   rsValue, rtValue, immExt;

    assign rsId = ctrl.is_syscall ? REG_ID_WIDTH'(2) : REG_ID_WIDTH'(rsField);
    assign rtId = REG_ID_WIDTH'(rtField);

    register_file #(.DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT)) u_regs (
        .clock_i        (clock),
        .reset_n_i      (reset_n),
        .write_en_i     (reg_write_W),
        .write_id_i     (writeback_id),
        .write_value_i  (writeback_value),
        .read_id_a_i    (rsId),
        .read_value_a_o (rsValue),
        .read_id_b_i    (rtId),
        .read_value_b_o (rtValue)
    );

    assign immExt = ctrl.zero_ext ? {{(DATA_WIDTH-16){1'b0}}, imm16}
                                  : {{(DATA_WIDTH-16){imm16[15]}}, imm16};

    always_comb begin
        destId = '0;
        case (ctrl.dest_sel)
            DEST_RD:   destId = REG_ID_WIDTH'(rdField);
            DEST_RT:   destId = rtId;
            DEST_LINK: destId = REG_ID_WIDTH'(LINK_REG);
            default:   destId = '0;
        endcase
    end

    logic                       outValid_q, outRegWrite_q, outMemToReg_q, outMemWrite_q;
    logic                       outAluSrc_q, outLink_q;
    logic [3:0]                 outAluOp_q;
    logic [4:0]                 outShamt_q;
    logic [REG_ID_WIDTH-1:0]    outDestId_q;
    logic [DATA_WIDTH-1:0]      outRsValue_q, outRtValue_q, outImmediate_q, outLinkValue_q;
    logic                       halted_q, halted_d;
    logic [STALL_CNT_WIDTH-1:0] stallCount_q, stallCount_d;
    logic                       loadEn, hazard, fire, takeRedirect;

    assign loadEn = out_ready || !outValid_q;
    assign hazard = outValid_q && outMemToReg_q && outRegWrite_q && (outDestId_q != '0) &&
                    ((ctrl.reads_rs && outDestId_q == rsId) || (ctrl.reads_rt && outDestId_q == rtId));
    assign in_ready = loadEn && !hazard && !halted_q;
    assign fire     = in_valid && in_ready;

    assign takeRedirect = (ctrl.is_beq && rsValue == rtValue) || (ctrl.is_bne && rsValue != rtValue) ||
                          ctrl.is_jtarget || ctrl.is_jr;
    assign jump = fire && takeRedirect;

    always_comb begin
        jump_address = pc_plus_four + (immExt << 2);
        if (ctrl.is_jr)
            jump_address = rsValue;
        else if (ctrl.is_jtarget)
            jump_address = {pc_plus_four[DATA_WIDTH-1:28], target26, 2'b00};
    end

    always_comb begin
        halted_d     = halted_q;
        stallCount_d = stallCount_q;
        if (fire && ctrl.is_syscall && rsValue == DATA_WIDTH'(SYSCALL_EXIT))
            halted_d = 1'b1;
        if (in_valid && loadEn && hazard && stallCount_q != '1)
            stallCount_d = stallCount_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            halted_q     <= 1'b0;
            stallCount_q <= '0;
        end else begin
            halted_q     <= halted_d;
            stallCount_q <= stallCount_d;
        end
    end

    // Fields only change on an accepted instruction; a bubble just clears valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outValid_q     <= 1'b0;
            outRegWrite_q  <= 1'b0;
            outMemToReg_q  <= 1'b0;
            outMemWrite_q  <= 1'b0;
            outAluSrc_q    <= 1'b0;
            outLink_q      <= 1'b0;
            outAluOp_q     <= '0;
            outShamt_q     <= '0;
            outDestId_q    <= '0;
            outRsValue_q   <= '0;
            outRtValue_q   <= '0;
            outImmediate_q <= '0;
            outLinkValue_q <= '0;
        end else if (loadEn) begin
            outValid_q <= fire;
            if (fire) begin
                outRegWrite_q  <= ctrl.reg_write;
                outMemToReg_q  <= ctrl.mem_to_reg;
                outMemWrite_q  <= ctrl.mem_write;
                outAluSrc_q    <= ctrl.alu_src;
                outLink_q      <= ctrl.link;
                outAluOp_q     <= ctrl.alu_op;
                outShamt_q     <= shamtField;
                outDestId_q    <= destId;
                outRsValue_q   <= rsValue;
                outRtValue_q   <= rtValue;
                outImmediate_q <= immExt;
                outLinkValue_q <= pc_plus_four;
            end
        end
    end

    assign out_valid      = outValid_q;
    assign out_reg_write  = outRegWrite_q;
    assign out_mem_to_reg = outMemToReg_q;
    assign out_mem_write  = outMemWrite_q;
    assign out_alu_src    = outAluSrc_q;
    assign out_link       = outLink_q;
    assign out_alu_op     = outAluOp_q;
    assign out_shamt      = outShamt_q;
    assign out_dest_id    = outDestId_q;
    assign out_rs_value   = outRsValue_q;
    assign out_rt_value   = outRtValue_q;
    assign out_immediate  = outImmediate_q;
    assign out_link_value = outLinkValue_q;
    assign halted         = halted_q;
    assign stall_count    = stallCount_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: reset, bypass, branches, load-use,
// backpressure, jal/jr, immediate extension and the exit halt.
module tb_decode_stage_pipelined;
    import decode_pkg::*;

    logic        clock, reset_n, in_valid, in_ready, reg_write_W, out_valid, out_ready;
    logic [31:0] instruction, pc_plus_four, writeback_value;
    logic [4:0]  writeback_id, out_dest_id, out_shamt;
    logic [31:0] out_rs_value, out_rt_value, out_immediate, out_link_value, jump_address;
    logic        out_reg_write, out_mem_to_reg, out_mem_write, out_alu_src, out_link, jump, halted;
    logic [3:0]  out_alu_op;
    logic [15:0] stall_count;

    int compared   = 0;
    int mismatched = 0;

    decode_stage_pipelined dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_plus_four(pc_plus_four), .reg_write_W(reg_write_W),
        .writeback_id(writeback_id), .writeback_value(writeback_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_value(out_rs_value), .out_rt_value(out_rt_value),
        .out_immediate(out_immediate), .out_link_value(out_link_value),
        .out_dest_id(out_dest_id), .out_shamt(out_shamt),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_write(out_mem_write), .out_alu_src(out_alu_src), .out_link(out_link),
        .out_alu_op(out_alu_op), .jump(jump), .jump_address(jump_address),
        .halted(halted), .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] encR(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] encI(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] encJ(input int op, input logic [25:0] target);
        return {6'(op), target};
    endfunction

    task automatic writeReg(input logic [4:0] id, input logic [31:0] value);
        @(negedge clock);
        in_valid = 1'b0; reg_write_W = 1'b1; writeback_id = id; writeback_value = value;
        @(posedge clock); #1;
        reg_write_W = 1'b0;
    endtask

    task automatic driveInstr(input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clock);
        in_valid = 1'b1; instruction = instr; pc_plus_four = pc;
        #1;
    endtask

    task automatic stepEdge();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; reg_write_W = 1'b0;
        instruction = '0; pc_plus_four = '0; writeback_id = '0; writeback_value = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1; #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %0h want 0", out_valid); end
        compared++; if (stall_count !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_stall: got %0h want 0", stall_count); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %0h want 1", in_ready); end
        driveInstr(encI(6'h08, 0, 3, 16'd5), 32'h40);
        stepEdge();
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL pre_reset_valid: got %0h want 1", out_valid); end
        compared++; if (out_immediate !== 32'd5) begin mismatched++; $display("[TB] FAIL pre_reset_imm: got %0h want 5", out_immediate); end
        @(negedge clock);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_valid: got %0h want 0", out_valid); end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_halted: got %0h want 0", halted); end
        compared++; if (out_immediate !== 32'd0) begin mismatched++; $display("[TB] FAIL midreset_imm: got %0h want 0", out_immediate); end
        compared++; if (out_dest_id !== 5'd0) begin mismatched++; $display("[TB] FAIL midreset_dest: got %0h want 0", out_dest_id); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_writeback();
        writeReg(5'd5, 32'h1234);
        driveInstr(encR(5, 0, 6, 0, 6'h20), 32'h100);
        stepEdge();
        compared++; if (out_rs_value !== 32'h1234) begin mismatched++; $display("[TB] FAIL add_rs: got %0h want 1234", out_rs_value); end
        compared++; if (out_dest_id !== 5'd6) begin mismatched++; $display("[TB] FAIL add_dest: got %0h want 6", out_dest_id); end
        compared++; if (out_reg_write !== 1'b1 || out_alu_src !== 1'b0) begin mismatched++; $display("[TB] FAIL add_ctrl: got rw=%0h src=%0h want rw=1 src=0", out_reg_write, out_alu_src); end
        compared++; if (out_alu_op !== ALU_OP_ADD) begin mismatched++; $display("[TB] FAIL add_aluop: got %0h want %0h", out_alu_op, ALU_OP_ADD); end
        // writeback to $0 must neither bypass nor stick
        @(negedge clock);
        reg_write_W = 1'b1; writeback_id = 5'd0; writeback_value = 32'hDEAD;
        in_valid = 1'b1; instruction = encR(0, 5, 7, 0, 6'h20); pc_plus_four = 32'h104;
        stepEdge();
        reg_write_W = 1'b0;
        compared++; if (out_rs_value !== 32'd0) begin mismatched++; $display("[TB] FAIL r0_bypass: got %0h want 0", out_rs_value); end
        driveInstr(encR(0, 0, 7, 0, 6'h20), 32'h108);
        stepEdge();
        compared++; if (out_rs_value !== 32'd0) begin mismatched++; $display("[TB] FAIL r0_write: got %0h want 0", out_rs_value); end
    endtask

    task automatic test_bypass_branch();
        writeReg(5'd9, 32'hAA);
        @(negedge clock);
        reg_write_W = 1'b1; writeback_id = 5'd8; writeback_value = 32'hAA;
        in_valid = 1'b1; instruction = encI(6'h04, 8, 9, 16'd3); pc_plus_four = 32'h200;
        #1;
        compared++; if (jump !== 1'b1) begin mismatched++; $display("[TB] FAIL beq_bypass_jump: got %0h want 1", jump); end
        compared++; if (jump_address !== 32'h20C) begin mismatched++; $display("[TB] FAIL beq_bypass_addr: got %0h want 20c", jump_address); end
        stepEdge();
        reg_write_W = 1'b0;
        driveInstr(encI(6'h05, 8, 9, 16'd5), 32'h210);
        compared++; if (jump !== 1'b0) begin mismatched++; $display("[TB] FAIL bne_equal_jump: got %0h want 0", jump); end
        driveInstr(encI(6'h05, 8, 0, 16'hFFFE), 32'h300);
        compared++; if (jump !== 1'b1) begin mismatched++; $display("[TB] FAIL bne_back_jump: got %0h want 1", jump); end
        compared++; if (jump_address !== 32'h2F8) begin mismatched++; $display("[TB] FAIL bne_back_addr: got %0h want 2f8", jump_address); end
        @(negedge clock);
        in_valid = 1'b0; instruction = encI(6'h04, 8, 9, 16'd3); #1;
        compared++; if (jump !== 1'b0) begin mismatched++; $display("[TB] FAIL beq_no_valid_jump: got %0h want 0", jump); end
    endtask

    task automatic test_load_use();
        driveInstr(encI(6'h23, 1, 4, 16'd0), 32'h400);
        stepEdge();
        compared++; if (out_mem_to_reg !== 1'b1 || out_dest_id !== 5'd4) begin mismatched++; $display("[TB] FAIL lw_fields: got m2r=%0h dest=%0h want m2r=1 dest=4", out_mem_to_reg, out_dest_id); end
        driveInstr(encI(6'h08, 4, 5, 16'd1), 32'h404);
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_in_ready: got %0h want 0", in_ready); end
        stepEdge();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_bubble: got %0h want 0", out_valid); end
        compared++; if (stall_count !== 16'd1) begin mismatched++; $display("[TB] FAIL lu_stall1: got %0h want 1", stall_count); end
        driveInstr(encI(6'h08, 4, 5, 16'd1), 32'h404);
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL lu_resume_ready: got %0h want 1", in_ready); end
        stepEdge();
        compared++; if (out_valid !== 1'b1 || out_dest_id !== 5'd5 || out_immediate !== 32'd1) begin mismatched++; $display("[TB] FAIL lu_addi_issue: got v=%0h dest=%0h imm=%0h want v=1 dest=5 imm=1", out_valid, out_dest_id, out_immediate); end
        driveInstr(encI(6'h23, 1, 4, 16'd0), 32'h408);
        stepEdge();
        driveInstr(encI(6'h2B, 1, 4, 16'd8), 32'h40C);
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_sw_ready: got %0h want 0", in_ready); end
        stepEdge();
        compared++; if (stall_count !== 16'd2) begin mismatched++; $display("[TB] FAIL lu_stall2: got %0h want 2", stall_count); end
        driveInstr(encI(6'h2B, 1, 4, 16'd8), 32'h40C);
        stepEdge();
        compared++; if (out_mem_write !== 1'b1 || out_reg_write !== 1'b0 || out_immediate !== 32'd8) begin mismatched++; $display("[TB] FAIL sw_fields: got mw=%0h rw=%0h imm=%0h want mw=1 rw=0 imm=8", out_mem_write, out_reg_write, out_immediate); end
        driveInstr(encI(6'h23, 1, 0, 16'd0), 32'h410);
        stepEdge();
        driveInstr(encI(6'h08, 0, 5, 16'd1), 32'h414);
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL lu_r0_ready: got %0h want 1", in_ready); end
        stepEdge();
        compared++; if (out_valid !== 1'b1 || stall_count !== 16'd2) begin mismatched++; $display("[TB] FAIL lu_r0_issue: got v=%0h stall=%0h want v=1 stall=2", out_valid, stall_count); end
    endtask

    task automatic test_backpressure();
        driveInstr(encR(5, 0, 6, 0, 6'h20), 32'h500);
        stepEdge();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            out_ready = 1'b0; in_valid = 1'b1; instruction = encJ(6'h02, 26'h10); pc_plus_four = 32'h504;
            #1;
            compared++; if (in_ready !== 1'b0 || jump !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ready_jump[%0d]: got rdy=%0h jump=%0h want 0 0", i, in_ready, jump); end
            stepEdge();
            compared++; if (out_valid !== 1'b1 || out_rs_value !== 32'h1234 || out_dest_id !== 5'd6) begin mismatched++; $display("[TB] FAIL bp_hold[%0d]: got v=%0h rs=%0h dest=%0h want 1 1234 6", i, out_valid, out_rs_value, out_dest_id); end
            compared++; if (stall_count !== 16'd2) begin mismatched++; $display("[TB] FAIL bp_stall[%0d]: got %0h want 2", i, stall_count); end
        end
        @(negedge clock);
        out_ready = 1'b1; instruction = encI(6'h08, 0, 7, 16'd9); #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release_ready: got %0h want 1", in_ready); end
        stepEdge();
        compared++; if (out_dest_id !== 5'd7 || out_immediate !== 32'd9) begin mismatched++; $display("[TB] FAIL bp_release_issue: got dest=%0h imm=%0h want 7 9", out_dest_id, out_immediate); end
    endtask

    task automatic test_jal_jr();
        driveInstr(encJ(6'h03, 26'h0100000), 32'h00400008);
        compared++; if (jump !== 1'b1 || jump_address !== 32'h00400000) begin mismatched++; $display("[TB] FAIL jal_redirect: got j=%0h addr=%0h want 1 00400000", jump, jump_address); end
        stepEdge();
        compared++; if (out_dest_id !== 5'd31 || out_link !== 1'b1 || out_reg_write !== 1'b1) begin mismatched++; $display("[TB] FAIL jal_ctrl: got dest=%0h link=%0h rw=%0h want 31 1 1", out_dest_id, out_link, out_reg_write); end
        compared++; if (out_link_value !== 32'h00400008) begin mismatched++; $display("[TB] FAIL jal_link_value: got %0h want 00400008", out_link_value); end
        writeReg(5'd31, 32'h00401234);
        driveInstr(encR(31, 0, 0, 0, 6'h08), 32'h00400004);
        compared++; if (jump !== 1'b1 || jump_address !== 32'h00401234) begin mismatched++; $display("[TB] FAIL jr_redirect: got j=%0h addr=%0h want 1 00401234", jump, jump_address); end
        driveInstr(encJ(6'h02, 26'h3FFFFFF), 32'hA0000010);
        compared++; if (jump !== 1'b1 || jump_address !== 32'hAFFFFFFC) begin mismatched++; $display("[TB] FAIL j_redirect: got j=%0h addr=%0h want 1 affffffc", jump, jump_address); end
        stepEdge();
        compared++; if (out_reg_write !== 1'b0 || out_link !== 1'b0) begin mismatched++; $display("[TB] FAIL j_ctrl: got rw=%0h link=%0h want 0 0", out_reg_write, out_link); end
    endtask

    task automatic test_immediates();
        driveInstr(encI(6'h0C, 0, 3, 16'h8001), 32'h600);
        stepEdge();
        compared++; if (out_immediate !== 32'h00008001 || out_alu_src !== 1'b1) begin mismatched++; $display("[TB] FAIL andi_imm: got imm=%0h src=%0h want 00008001 1", out_immediate, out_alu_src); end
        driveInstr(encI(6'h0D, 0, 3, 16'hFFFF), 32'h604);
        stepEdge();
        compared++; if (out_immediate !== 32'h0000FFFF) begin mismatched++; $display("[TB] FAIL ori_imm: got %0h want 0000ffff", out_immediate); end
        driveInstr(encI(6'h0A, 0, 3, 16'h8000), 32'h608);
        stepEdge();
        compared++; if (out_immediate !== 32'hFFFF8000 || out_alu_op !== ALU_OP_SLT) begin mismatched++; $display("[TB] FAIL slti_imm: got imm=%0h op=%0h want ffff8000 %0h", out_immediate, out_alu_op, ALU_OP_SLT); end
        driveInstr(encI(6'h08, 0, 3, 16'hFFFF), 32'h60C);
        stepEdge();
        compared++; if (out_immediate !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL addi_neg_imm: got %0h want ffffffff", out_immediate); end
        driveInstr(encR(0, 5, 7, 4, 6'h00), 32'h610);
        stepEdge();
        compared++; if (out_shamt !== 5'd4 || out_rt_value !== 32'h1234 || out_alu_op !== ALU_OP_SLL) begin mismatched++; $display("[TB] FAIL sll_fields: got sh=%0h rt=%0h op=%0h want 4 1234 %0h", out_shamt, out_rt_value, out_alu_op, ALU_OP_SLL); end
        driveInstr({6'h3F, 26'h1234567}, 32'h614);
        compared++; if (jump !== 1'b0) begin mismatched++; $display("[TB] FAIL unknown_jump: got %0h want 0", jump); end
        stepEdge();
        compared++; if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || out_mem_write !== 1'b0 || out_link !== 1'b0) begin mismatched++; $display("[TB] FAIL unknown_nop: got v=%0h rw=%0h mw=%0h link=%0h want 1 0 0 0", out_valid, out_reg_write, out_mem_write, out_link); end
    endtask

    task automatic test_halt();
        writeReg(5'd2, 32'd9);
        driveInstr(encR(0, 0, 0, 0, 6'h0C), 32'h700);
        stepEdge();
        compared++; if (halted !== 1'b0) begin mismatched++; $display("[TB] FAIL syscall_not_exit: got %0h want 0", halted); end
        writeReg(5'd2, 32'd10);
        driveInstr(encR(0, 0, 0, 0, 6'h0C), 32'h704);
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL syscall_ready: got %0h want 1", in_ready); end
        stepEdge();
        compared++; if (halted !== 1'b1 || out_valid !== 1'b1 || out_reg_write !== 1'b0) begin mismatched++; $display("[TB] FAIL syscall_halt: got h=%0h v=%0h rw=%0h want 1 1 0", halted, out_valid, out_reg_write); end
        for (int i = 0; i < 12; i++) begin
            driveInstr(encR(5, 0, 6, 0, 6'h20), 32'h708);
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_ready[%0d]: got %0h want 0", i, in_ready); end
        end
        stepEdge();
        compared++; if (out_valid !== 1'b0 || halted !== 1'b1) begin mismatched++; $display("[TB] FAIL halt_drain: got v=%0h h=%0h want 0 1", out_valid, halted); end
        @(negedge clock);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        compared++; if (halted !== 1'b0 || stall_count !== 16'd0) begin mismatched++; $display("[TB] FAIL halt_reset: got h=%0h stall=%0h want 0 0", halted, stall_count); end
        @(negedge clock);
        reset_n = 1'b1;
        driveInstr(encR(5, 0, 6, 0, 6'h20), 32'h800);
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_ready: got %0h want 1", in_ready); end
        stepEdge();
        compared++; if (out_valid !== 1'b1 || out_rs_value !== 32'd0) begin mismatched++; $display("[TB] FAIL regfile_cleared: got v=%0h rs=%0h want 1 0", out_valid, out_rs_value); end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_bypass_branch();
        test_load_use();
        test_backpressure();
        test_jal_jr();
        test_immediates();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
